bin_to_bcd_loader: RTL and testbench



---
 rtl/ss_pkg.sv | 15 +
 rtl/bcd_add3.sv | 17 +
 rtl/bin_to_bcd_loader.sv | 116 +++++++++++
 tb/tb_bin_to_bcd_loader.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ss_pkg.sv
// Shared types and constants for the binary-to-BCD loader feeding the
// seven-segment display stage.
package ss_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam bcd_digit_t BCD_ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// Shift-and-add-3 correction for one BCD nibble: digits of 5 or more get 3
// added so the following left shift carries correctly into the next digit.
module bcd_add3
  import ss_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t corrected
);

  always_comb begin
    corrected = digit;
    if (digit >= BCD_ADD3_THRESH) begin
      corrected = digit + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_loader.sv
// Sequential binary-to-BCD converter, one bit per cycle, that hands a packed BCD
// word, digit enable mask and overflow flag to the display stage with a load pulse.
module bin_to_bcd_loader
  import ss_pkg::*;
#(
  parameter int BIN_WIDTH  = 20,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    start,
  input  logic [BIN_WIDTH-1:0]    bin_in,
  input  logic                    blank_lz,
  output logic                    busy,
  output logic [4*NUM_DIGITS-1:0] number,
  output logic [NUM_DIGITS-1:0]   en_mask,
  output logic                    overflow,
  output logic                    load_enable
);

  // One spare digit so the full range of a 20-bit input fits during shifting.
  localparam int BCD_W = 4 * (NUM_DIGITS + 1);
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam longint unsigned MAX_VAL = (64'd10 ** NUM_DIGITS) - 64'd1;
  localparam logic [4*NUM_DIGITS-1:0] ALL_NINES = {NUM_DIGITS{4'd9}};

  state_t                 state;
  state_t                 next_state;
  logic [BIN_WIDTH-1:0]   bin_sr;
  logic [BCD_W-1:0]       bcd_sr;
  logic [BCD_W-1:0]       bcd_adj;
  logic [CNT_W-1:0]       cnt;
  logic                   lz_ff;
  logic                   ovf_ff;
  logic [NUM_DIGITS-1:0]  mask_calc;
  logic                   any_nz;

  for (genvar g = 0; g < NUM_DIGITS + 1; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit     (bcd_sr[4*g +: 4]),
      .corrected (bcd_adj[4*g +: 4])
    );
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (cnt == CNT_W'(BIN_WIDTH - 1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // A digit is shown when it or any more significant digit is nonzero; digit 0 always shows.
  always_comb begin
    mask_calc = '1;
    any_nz    = 1'b0;
    if (lz_ff) begin
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
        any_nz       = any_nz | (bcd_sr[4*i +: 4] != 4'd0);
        mask_calc[i] = any_nz;
      end
      mask_calc[0] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      bin_sr      <= '0;
      bcd_sr      <= '0;
      cnt         <= '0;
      lz_ff       <= 1'b0;
      ovf_ff      <= 1'b0;
      number      <= '0;
      en_mask     <= '0;
      overflow    <= 1'b0;
      load_enable <= 1'b0;
    end else begin
      load_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr <= bin_in;
            lz_ff  <= blank_lz;
            bcd_sr <= '0;
            cnt    <= '0;
            ovf_ff <= (64'(bin_in) > MAX_VAL);
          end
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
          cnt              <= cnt + CNT_W'(1);
        end
        DONE: begin
          number      <= ovf_ff ? ALL_NINES : bcd_sr[4*NUM_DIGITS-1:0];
          en_mask     <= ovf_ff ? '1 : mask_calc;
          overflow    <= ovf_ff;
          load_enable <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_loader.sv
// Self-checking bench for bin_to_bcd_loader: a table of directed conversions
// followed by hand-written sequences for busy, back-to-back and reset cases.
module tb_bin_to_bcd_loader;

  logic        CLK;
  logic        nRST;
  logic        start;
  logic [19:0] bin_in;
  logic        blank_lz;
  logic        busy;
  logic [23:0] number;
  logic [5:0]  en_mask;
  logic        overflow;
  logic        load_enable;

  int checks_total  = 0;
  int checks_passed = 0;
  int le_count      = 0;

  typedef struct {
    logic [19:0] bin;
    logic        blank;
    logic [23:0] exp_number;
    logic [5:0]  exp_mask;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[9];

  bin_to_bcd_loader #(
    .BIN_WIDTH  (20),
    .NUM_DIGITS (6)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .start       (start),
    .bin_in      (bin_in),
    .blank_lz    (blank_lz),
    .busy        (busy),
    .number      (number),
    .en_mask     (en_mask),
    .overflow    (overflow),
    .load_enable (load_enable)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (load_enable) le_count++;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the edge that samples start.
  task automatic apply_stimulus(input logic [19:0] v, input logic b);
    bin_in   = v;
    blank_lz = b;
    start    = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_load(output int lat);
    lat = 0;
    while (!load_enable && lat < 40) begin
      @(posedge CLK);
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  initial begin
    int lat;
    int le_before;

    vecs[0] = '{20'd0,       1'b1, 24'h000000, 6'b000001, 1'b0};
    vecs[1] = '{20'd123456,  1'b1, 24'h123456, 6'b111111, 1'b0};
    vecs[2] = '{20'd4095,    1'b1, 24'h004095, 6'b001111, 1'b0};
    vecs[3] = '{20'd4095,    1'b0, 24'h004095, 6'b111111, 1'b0};
    vecs[4] = '{20'd1048575, 1'b1, 24'h999999, 6'b111111, 1'b1};
    vecs[5] = '{20'd999999,  1'b1, 24'h999999, 6'b111111, 1'b0};
    vecs[6] = '{20'd1000000, 1'b0, 24'h999999, 6'b111111, 1'b1};
    vecs[7] = '{20'd100000,  1'b1, 24'h100000, 6'b111111, 1'b0};
    vecs[8] = '{20'd7,       1'b1, 24'h000007, 6'b000001, 1'b0};

    nRST     = 1'b0;
    start    = 1'b0;
    bin_in   = '0;
    blank_lz = 1'b0;
    idle_cycles(3);
    check_output("reset_number",   32'(number),      32'h0);
    check_output("reset_mask",     32'(en_mask),     32'h0);
    check_output("reset_overflow", 32'(overflow),    32'h0);
    check_output("reset_load",     32'(load_enable), 32'h0);
    check_output("reset_busy",     32'(busy),        32'h0);
    nRST = 1'b1;
    idle_cycles(2);

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].bin, vecs[i].blank);
      check_output($sformatf("v%0d_busy", i), 32'(busy), 32'h1);
      wait_load(lat);
      check_output($sformatf("v%0d_latency", i),  32'(lat),      32'd21);
      check_output($sformatf("v%0d_number", i),   32'(number),   32'(vecs[i].exp_number));
      check_output($sformatf("v%0d_mask", i),     32'(en_mask),  32'(vecs[i].exp_mask));
      check_output($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      idle_cycles(1);
      check_output($sformatf("v%0d_pulse_end", i), 32'(load_enable), 32'h0);
      check_output($sformatf("v%0d_hold", i),      32'(number),      32'(vecs[i].exp_number));
      check_output($sformatf("v%0d_idle", i),      32'(busy),        32'h0);
      idle_cycles(2);
    end

    // start while busy must be dropped, not queued
    le_before = le_count;
    apply_stimulus(20'd42, 1'b1);
    idle_cycles(4);
    apply_stimulus(20'd7, 1'b1);
    wait_load(lat);
    check_output("busy_ignore_number", 32'(number), 32'h000042);
    idle_cycles(30);
    check_output("busy_ignore_pulses", 32'(le_count - le_before), 32'd1);
    check_output("busy_ignore_hold",   32'(number), 32'h000042);

    // start in the load_enable cycle is accepted
    apply_stimulus(20'd42, 1'b1);
    wait_load(lat);
    check_output("b2b_first_number", 32'(number), 32'h000042);
    apply_stimulus(20'd555, 1'b1);
    wait_load(lat);
    check_output("b2b_latency", 32'(lat),    32'd21);
    check_output("b2b_number",  32'(number), 32'h000555);
    check_output("b2b_mask",    32'(en_mask), 32'b000111);
    idle_cycles(2);

    // reset mid-conversion abandons it
    le_before = le_count;
    apply_stimulus(20'd999, 1'b1);
    idle_cycles(9);
    nRST = 1'b0;
    idle_cycles(1);
    check_output("midrst_number", 32'(number),      32'h0);
    check_output("midrst_mask",   32'(en_mask),     32'h0);
    check_output("midrst_busy",   32'(busy),        32'h0);
    check_output("midrst_load",   32'(load_enable), 32'h0);
    nRST = 1'b1;
    idle_cycles(30);
    check_output("midrst_no_pulse", 32'(le_count - le_before), 32'd0);
    apply_stimulus(20'd31, 1'b1);
    wait_load(lat);
    check_output("postrst_latency", 32'(lat),      32'd21);
    check_output("postrst_number",  32'(number),   32'h000031);
    check_output("postrst_mask",    32'(en_mask),  32'b000011);
    check_output("postrst_ovf",     32'(overflow), 32'h0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
